// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch unit with a small in-order instruction buffer
// Optional halt-word detection is built in when IFETCH_HALT_DETECT_EN is defined.
module ifetch_unit #(
    parameter logic [31:0] PC_INIT   = 32'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_npc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halt
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {FETCH, FULL, HALTED} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   buf_word [BUF_DEPTH];
    logic [31:0]   buf_pc   [BUF_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;
    logic          halt_word;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign imemREN    = (state == FETCH);
    assign imemaddr   = pc;
    assign push       = imemREN && ihit && !redirect;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst       = inst_valid ? buf_word[head] : '0;
    assign inst_pc    = inst_valid ? buf_pc[head] : '0;
    assign inst_npc   = inst_valid ? buf_pc[head] + 32'd4 : '0;

`ifdef IFETCH_HALT_DETECT_EN
    assign halt_word = push && (imemload == 32'hFFFF_FFFF);
    assign halt      = (state == HALTED);
`else
    assign halt_word = 1'b0;
    assign halt      = 1'b0;
`endif

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
            pc    <= PC_INIT & ~32'h3;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            // Redirect flushes everything, including a same-cycle hit and any halt.
            state <= FETCH;
            pc    <= redirect_pc & ~32'h3;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                buf_word[tail] <= imemload;
                buf_pc[tail]   <= pc;
                tail           <= next_ptr(tail);
                pc             <= pc + 32'd4;
            end
            if (pop)
                head <= next_ptr(head);
            count <= count_nxt;
            case (state)
                FETCH: begin
                    if (halt_word)
                        state <= HALTED;
                    else if (count_nxt == CW'(BUF_DEPTH))
                        state <= FULL;
                end
                FULL: begin
                    if (pop)
                        state <= FETCH;
                end
                HALTED: state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0, PC loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries (legal 1..4).
REQ-003 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imemREN  output  1  instruction read request to memory side.
REQ-006 SHALL have port imemaddr  output  32  word address of current request.
REQ-007 SHALL have port ihit  input  1  memory response valid for current imemaddr, same cycle.
REQ-008 SHALL have port imemload  input  32  instruction word, valid when ihit=1.
REQ-009 SHALL have port inst_valid  output  1  head of buffer holds an instruction.
REQ-010 SHALL have port inst_ready  input  1  decode consumes head when inst_valid=1.
REQ-011 SHALL have port inst  output  32  head instruction word.
REQ-012 SHALL have port inst_pc  output  32  address of head instruction.
REQ-013 SHALL have port inst_npc  output  32  inst_pc+4, modulo 2^32.
REQ-014 SHALL have port redirect  input  1  branch/jump taken, flush and refetch.
REQ-015 SHALL have port redirect_pc  input  32  new fetch target.
REQ-016 SHALL have port halt  output  1  halt word fetched and fetching stopped.

Function
REQ-017 SHALL implement states FETCH, FULL, HALTED; reset state FETCH.
REQ-018 SHALL assert imemREN only in FETCH and clear it when the buffer is full; imemaddr SHALL equal the fetch PC, and imemaddr[1:0] SHALL be 2'b00.
REQ-019 SHALL, on ihit=1 with imemREN=1 and no redirect, push {imemload, PC} into the buffer and advance PC by 4 in the same edge (wrap 32'hFFFFFFFC->0).
REQ-020 SHALL hold imemaddr stable while ihit=0; there is no timeout.
REQ-021 SHALL pop the head on inst_valid&&inst_ready; push and pop in one cycle SHALL leave the count unchanged, including when the buffer is full.
REQ-022 SHALL go FETCH->FULL when count reaches BUF_DEPTH with no pop, and FULL->FETCH on the next pop.
REQ-023 SHALL, on redirect=1, flush all entries, discard any same-cycle ihit, load PC=redirect_pc with bits[1:0] forced to 0, and enter FETCH; the first request to the new PC SHALL appear the next cycle.
REQ-024 SHALL give redirect priority over push, pop and halt detection in the same cycle.
REQ-025 SHALL deliver instructions in fetch order, with zero-cycle latency from push to inst_valid on the cycle after the push edge.
REQ-026 SHALL drive inst, inst_pc and inst_npc to 0 when inst_valid=0.

Reset
REQ-027 SHALL, with RST=1 at an edge, set PC=PC_INIT, empty the buffer, enter FETCH and clear halt; outputs after reset: imemREN=1, imemaddr=PC_INIT, inst_valid=0, halt=0.
REQ-028 SHALL let reset override every in-flight request, redirect and HALTED state, and drop any same-cycle ihit.

Configuration
REQ-029 SHALL use macro IFETCH_HALT_DETECT_EN. When defined, a pushed word equal to 32'hFFFFFFFF SHALL still enter the buffer, the unit SHALL enter HALTED with imemREN=0 and set halt=1 from the next cycle; a later redirect SHALL leave HALTED and clear halt. When undefined, 32'hFFFFFFFF is an ordinary word, HALTED is unreachable and halt is tied 0.

Verification
REQ-030 Reset with PC_INIT=0, ihit=1 every cycle, inst_ready=1 -> inst_pc sequence 0,4,8,C on consecutive cycles, inst_npc=inst_pc+4.
REQ-031 inst_ready=0, ihit=1, BUF_DEPTH=2 -> two pushes (pc 0,4), then imemREN=0 and state FULL; one pop -> imemREN=1 with imemaddr=8.
REQ-032 redirect=1, redirect_pc=32'h43 at the same cycle as ihit for addr 8 -> word dropped, buffer empty, next imemaddr=32'h40.
REQ-033 ihit held 0 for 5 cycles at addr 4 -> imemaddr=4 stable and inst_valid=0 after drain; ihit=1 -> pc 4 delivered.
REQ-034 With IFETCH_HALT_DETECT_EN, imemload=32'hFFFFFFFF at addr 24 -> word delivered with inst_pc=24, halt=1, imemREN=0 thereafter; redirect to 0 -> halt=0, fetch resumes at 0.
REQ-035 PC at 32'hFFFFFFFC with ihit=1 -> entry pc FFFFFFFC, inst_npc=0, next imemaddr=0.
